// File: rtl/wb_read_streamer.sv
// wb_read_streamer: bulk read engine. Accepts (start address, word count) commands, issues
// pipelined Wishbone reads and streams the returned words on AXI-Stream, with tlast on the
// final word of each command. A request is issued only when the return FIFO has room for its
// data, counting both what the FIFO holds and what is still in flight. This means a stalled
// sink never causes data loss.
//
// Optional feature: define WB_RD_TIMEOUT_EN to add an ack timeout and a sticky err output.
//
// Ports:
//   clk, areset             clock, asynchronous active-high reset
//   cmd_tvalid/cmd_tready   command handshake; cmd_addr = first word, cmd_len = word count
//   m_wb_*                  pipelined Wishbone read master (we tied to 0)
//   axis_*                  AXI-Stream output of read data, tlast on the last word
//   busy                    high whenever the engine is not idle
//   err                     (WB_RD_TIMEOUT_EN only) sticky ack-timeout flag
module wb_read_streamer #(
  parameter int unsigned ADDR_BITS      = 23,
  parameter int unsigned DATA_BYTES     = 2,
  parameter int unsigned LEN_BITS       = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    areset,
  output logic                    cmd_tready,
  input  logic                    cmd_tvalid,
  input  logic [ADDR_BITS-1:0]    cmd_addr,
  input  logic [LEN_BITS-1:0]     cmd_len,
  output logic [ADDR_BITS-1:0]    m_wb_addr,
  output logic                    m_wb_we,
  output logic                    m_wb_stb,
  output logic                    m_wb_cyc,
  input  logic                    m_wb_stall,
  input  logic                    m_wb_ack,
  input  logic [DATA_BYTES*8-1:0] m_wb_dat_s2m,
  input  logic                    axis_tready,
  output logic                    axis_tvalid,
  output logic                    axis_tlast,
  output logic [DATA_BYTES*8-1:0] axis_tdata,
`ifdef WB_RD_TIMEOUT_EN
  output logic                    err,
`endif
  output logic                    busy
);

  localparam int unsigned DW = DATA_BYTES * 8;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LEN_BITS-1:0]   req_left_q, req_left_d;
  logic [LEN_BITS-1:0]   ack_left_q, ack_left_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         fifo_count_q, fifo_count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DW:0]           fifo_mem [FIFO_DEPTH];

  logic cmd_accept, has_credit, issue, ack_ok, push, pop, push_last;

`ifdef WB_RD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  assign err = err_q;
`endif

  assign cmd_tready = (state_q == StIdle) && !areset;
  assign cmd_accept = cmd_tvalid && cmd_tready;

  // Words held plus words in flight must stay within the FIFO.
  assign has_credit = ((CW+1)'(fifo_count_q) + (CW+1)'(outstanding_q)) < (CW+1)'(FIFO_DEPTH);

  assign m_wb_we   = 1'b0;
  assign m_wb_addr = addr_q;
  assign m_wb_stb  = (state_q == StReq) && (req_left_q != '0) && has_credit;
  assign m_wb_cyc  = (state_q == StReq) || ((state_q == StWait) && (ack_left_q != '0));
  assign busy      = (state_q != StIdle);

  assign issue     = m_wb_stb && !m_wb_stall;
  // Stray acks (nothing in flight) are dropped.
  assign ack_ok    = m_wb_ack && m_wb_cyc && (outstanding_q != '0);
  assign push      = ack_ok;
  assign push_last = (ack_left_q == LEN_BITS'(1));

  assign axis_tvalid = (fifo_count_q != '0);
  assign pop         = axis_tvalid && axis_tready;
  assign axis_tdata  = axis_tvalid ? fifo_mem[rd_ptr_q][DW-1:0] : '0;
  assign axis_tlast  = axis_tvalid ? fifo_mem[rd_ptr_q][DW] : 1'b0;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    req_left_d    = req_left_q;
    ack_left_d    = ack_left_q;
    outstanding_d = outstanding_q;
    fifo_count_d  = fifo_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          addr_d     = cmd_addr;
          req_left_d = cmd_len;
          ack_left_d = cmd_len;
          if (cmd_len != '0) state_d = StReq;
        end
      end
      StReq: begin
        if (issue) begin
          addr_d     = addr_q + ADDR_BITS'(1);
          req_left_d = req_left_q - LEN_BITS'(1);
          if (req_left_q == LEN_BITS'(1)) state_d = StWait;
        end
      end
      StWait: begin
        if (ack_left_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (ack_ok) ack_left_d = ack_left_q - LEN_BITS'(1);

    unique case ({issue, ack_ok})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

`ifdef WB_RD_TIMEOUT_EN
    err_d = err_q;
    tmo_d = tmo_q;
    if (cmd_accept) err_d = 1'b0;
    if ((state_q == StIdle) || ack_ok) tmo_d = '0;
    else if (outstanding_q != '0) tmo_d = tmo_q + TW'(1);
    // Abort: drop the bus cycle, forget in-flight requests and flush buffered data.
    if ((state_q != StIdle) && (outstanding_q != '0) && !ack_ok &&
        (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_d       = StIdle;
      req_left_d    = '0;
      ack_left_d    = '0;
      outstanding_d = '0;
      fifo_count_d  = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      tmo_d         = '0;
      err_d         = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      req_left_q    <= '0;
      ack_left_q    <= '0;
      outstanding_q <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
`ifdef WB_RD_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      req_left_q    <= req_left_d;
      ack_left_q    <= ack_left_d;
      outstanding_q <= outstanding_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
`ifdef WB_RD_TIMEOUT_EN
      tmo_q         <= tmo_d;
      err_q         <= err_d;
`endif
    end
  end

  // Storage needs no reset: the count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {push_last, m_wb_dat_s2m};
  end

endmodule
